lsq_commit_ordered: RTL
=======================

// Module: lsq_commit_ordered
// PURPOSE
//  In-order load/store queue between dispatch and the memory controller, in DEPTH entries.
//  - Resolves operands by snooping the ALU CDB and its own load results.
//  - Drains stores only after ROB commit; committed stores survive a flush.
//  - Sign/zero-extends load data and broadcasts it on the LSQ CDB.
// PARAMETERS
//  DEPTH_BITS 4        log2 of entry count; all 2**DEPTH_BITS entries usable
//  ROB_W      4        ROB alias width; alias 0 = "no dependency"
//  XLEN       32       data/address width
//  IO_BASE    32'h30000 first address of I/O space (used only with LSQ_IO_ORDER_EN)
// PORTS
//  clk           in  1      clock
//  rst           in  1      reset
//  rdy           in  1      global enable; 0 freezes all state
//  flush         in  1      misprediction rollback
//  iss_valid     in  1      enqueue request
//  iss_op        in  4      {is_store, is_unsigned, size[1:0]}; size 0=B,1=H,2=W
//  iss_rob       in  ROB_W  ROB alias of the instruction
//  iss_qi/iss_qj in  ROB_W  base/store-data producer alias
//  iss_vi/iss_vj in  XLEN   base/store-data value when q==0
//  iss_imm       in  XLEN   address offset
//  full          out 1      count == 2**DEPTH_BITS
//  commit_valid  in  1      ROB retire pulse
//  commit_rob    in  ROB_W  alias being retired
//  rob_head_id   in  ROB_W  oldest live ROB alias (LSQ_IO_ORDER_EN only)
//  alu_valid     in  1      ALU CDB valid
//  alu_rob       in  ROB_W  ALU CDB alias
//  alu_data      in  XLEN   ALU CDB value
//  mc_req        out 1      memory request; held until mc_done
//  mc_wr         out 1      1 = store
//  mc_size       out 2      byte-count code (0/1/2)
//  mc_addr       out XLEN   vi + imm, modulo 2**XLEN
//  mc_wdata      out XLEN   store data
//  mc_done       in  1      one-cycle completion pulse
//  mc_rdata      in  XLEN   raw load bytes, low-aligned
//  out_valid     out 1      LSQ CDB valid (one cycle)
//  out_rob       out ROB_W  LSQ CDB alias
//  out_data      out XLEN   extended load value; 0 for stores
// BEHAVIOUR
//  - Reset (rst synchronous, active-high): head=tail=count=cmt_cnt=0, state IDLE.
//    Outputs mc_req, mc_wr, mc_size, mc_addr, mc_wdata, out_valid, out_rob and out_data all 0.
//  - Enqueue: when iss_valid && !full, write entry at tail. Same-cycle ALU or own-CDB match on
//    iss_qi/iss_qj captures the value and writes q=0.
//  - Snoop: every cycle, entries whose q matches alu_rob (alu_valid) or out_rob (out_valid) clear q and take the data.
//  - Commit: when commit_valid matches a store entry's rob, set its cmt bit and cmt_cnt++.
//  - Store report: in IDLE, an uncommitted, unreported head store with qi=qj=0 pulses out_valid(rob, 0) once.
//  - FSM IDLE: when the head is ready, assert mc_req next cycle and go to WAIT. Ready means:
//    - valid, and qi==0, and (load, or store with cmt bit set);
//    - a store also needs qj==0.
//  - FSM WAIT: hold all mc_* stable until mc_done, then pop the head.
//    - Load: out_valid=1, out_data = mc_rdata sign- or zero-extended from 8/16 bits per is_unsigned.
//    - Store: cmt_cnt--, no broadcast. Deassert mc_req and return to IDLE.
//  - FSM DRAIN: on mc_done, discard the data with no out_valid, do not pop, go to IDLE.
//  - Latency: ready head to mc_req = 1 cycle; mc_done to out_valid = 1 cycle. Max 1 outstanding request.
//  - Flush (priority over enqueue and commit in the same cycle):
//    - Uncommitted entries are dropped: tail <= head + cmt_cnt (wraps), count <= cmt_cnt.
//    - Load in WAIT goes to DRAIN; a committed store in WAIT continues.
//    - out_valid is forced to 0.
//  - Wrap: head/tail are modulo 2**DEPTH_BITS; count disambiguates full vs empty.
//  - Simultaneous enqueue and pop: count unchanged; enqueue is allowed at full when a pop occurs the same cycle? No: full gates enqueue.
//  - Reset mid-transaction: state returns to IDLE at once; the memory controller is reset with the queue.
// CONFIGURATION
//  LSQ_IO_ORDER_EN defined: a load with address >= IO_BASE is ready only when rob_head_id == its rob.
//  LSQ_IO_ORDER_EN undefined: rob_head_id is ignored; all loads issue speculatively.
// TESTING
//  - LW base vi=0x100, imm=4, mc_rdata=0xDEADBEEF -> mc_addr=0x104, size=2; out_data=0xDEADBEEF.
//  - LB then LBU with mc_rdata=0x80 -> out_data 0xFFFFFF80, then 0x00000080.
//  - SW rob=3 with qj=5; ALU broadcasts 5/0x55 -> store report out_rob=3.
//    No mc_req until commit_rob=3; then mc_wr=1, mc_wdata=0x55.
//  - Fill 16 entries -> full=1 and a 17th iss_valid is ignored.
//    Pop one -> full=0; tail wraps to 0 correctly.
//  - Committed SW at head in flight, then 2 loads; flush -> the store completes.
//    Afterwards count=0 and no out_valid appears for the loads.
//  - LSQ_IO_ORDER_EN: LW to 0x30000, rob=7 -> no mc_req until rob_head_id=7.

Source files
------------

// File: rtl/lsq_commit_ordered_if.sv
// Bus bundle for lsq_commit_ordered: issue, commit, ALU snoop, memory controller and LSQ CDB.
// slave is the queue side, master is the dispatch/ROB/memory environment side.
interface lsq_commit_ordered_if #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
);
  logic             rdy;
  logic             flush;
  logic             iss_valid;
  logic [3:0]       iss_op;
  logic [ROB_W-1:0] iss_rob;
  logic [ROB_W-1:0] iss_qi;
  logic [ROB_W-1:0] iss_qj;
  logic [XLEN-1:0]  iss_vi;
  logic [XLEN-1:0]  iss_vj;
  logic [XLEN-1:0]  iss_imm;
  logic             full;
  logic             commit_valid;
  logic [ROB_W-1:0] commit_rob;
  logic [ROB_W-1:0] rob_head_id;
  logic             alu_valid;
  logic [ROB_W-1:0] alu_rob;
  logic [XLEN-1:0]  alu_data;
  logic             mc_req;
  logic             mc_wr;
  logic [1:0]       mc_size;
  logic [XLEN-1:0]  mc_addr;
  logic [XLEN-1:0]  mc_wdata;
  logic             mc_done;
  logic [XLEN-1:0]  mc_rdata;
  logic             out_valid;
  logic [ROB_W-1:0] out_rob;
  logic [XLEN-1:0]  out_data;

  modport slave (
    input  rdy, flush, iss_valid, iss_op, iss_rob, iss_qi, iss_qj, iss_vi, iss_vj, iss_imm,
           commit_valid, commit_rob, rob_head_id, alu_valid, alu_rob, alu_data,
           mc_done, mc_rdata,
    output full, mc_req, mc_wr, mc_size, mc_addr, mc_wdata, out_valid, out_rob, out_data
  );

  modport master (
    output rdy, flush, iss_valid, iss_op, iss_rob, iss_qi, iss_qj, iss_vi, iss_vj, iss_imm,
           commit_valid, commit_rob, rob_head_id, alu_valid, alu_rob, alu_data,
           mc_done, mc_rdata,
    input  full, mc_req, mc_wr, mc_size, mc_addr, mc_wdata, out_valid, out_rob, out_data
  );
endinterface

// File: rtl/lsq_commit_ordered.sv
// In-order load/store queue; stores drain only after ROB commit and survive a flush.
// Optional macro LSQ_IO_ORDER_EN: loads at or above IO_BASE wait until they are the ROB head.
module lsq_commit_ordered #(
  parameter int              DEPTH_BITS = 4,
  parameter int              ROB_W      = 4,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] IO_BASE    = XLEN'(32'h30000)
) (
  input logic                  clk,
  input logic                  rst,
  lsq_commit_ordered_if.slave  lsq
);
  localparam int N = 2 ** DEPTH_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic             st;
    logic             uns;
    logic [1:0]       sz;
    logic [ROB_W-1:0] rob;
    logic [ROB_W-1:0] qi;
    logic [ROB_W-1:0] qj;
    logic [XLEN-1:0]  vi;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  imm;
    logic             cmt;
    logic             rep;
  } ent_t;

  ent_t                  ent_q [N];
  ent_t                  ent_d [N];
  state_t                state_q, state_d;
  logic [DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d, off;
  logic [DEPTH_BITS:0]   count_q, count_d, cmt_cnt_q, cmt_cnt_d;
  logic                  mc_req_q, mc_req_d, mc_wr_q, mc_wr_d;
  logic [1:0]            mc_size_q, mc_size_d;
  logic [XLEN-1:0]       mc_addr_q, mc_addr_d, mc_wdata_q, mc_wdata_d;
  logic                  out_valid_q, out_valid_d;
  logic [ROB_W-1:0]      out_rob_q, out_rob_d;
  logic [XLEN-1:0]       out_data_q, out_data_d;

  ent_t            hd;
  logic [XLEN-1:0] hd_addr, ld_ext;
  logic            full, enq, pop, st_pop, cmt_hit, head_ready, report, io_block;

  // Pick up a pending operand from the ALU CDB or from our own load broadcast.
  function automatic logic [ROB_W+XLEN-1:0] resolve(input logic [ROB_W-1:0] q,
                                                    input logic [XLEN-1:0]  v);
    if (q != '0 && lsq.alu_valid && lsq.alu_rob == q) return {{ROB_W{1'b0}}, lsq.alu_data};
    if (q != '0 && out_valid_q && out_rob_q == q)     return {{ROB_W{1'b0}}, out_data_q};
    return {q, v};
  endfunction

  assign full    = (count_q == (DEPTH_BITS+1)'(N));
  assign hd      = ent_q[head_q];
  assign hd_addr = hd.vi + hd.imm;

`ifdef LSQ_IO_ORDER_EN
  assign io_block = !hd.st && (hd_addr >= IO_BASE) && (lsq.rob_head_id != hd.rob);
`else
  logic unused_io;
  assign unused_io = ^{lsq.rob_head_id, IO_BASE};
  assign io_block  = 1'b0;
`endif

  assign head_ready = (count_q != '0) && (hd.qi == '0) && !io_block &&
                      (!hd.st || (hd.cmt && hd.qj == '0));
  assign report     = (count_q != '0) && hd.st && !hd.cmt && !hd.rep &&
                      (hd.qi == '0) && (hd.qj == '0);

  always_comb begin
    case (hd.sz)
      2'd0:    ld_ext = {{(XLEN-8){~hd.uns & lsq.mc_rdata[7]}}, lsq.mc_rdata[7:0]};
      2'd1:    ld_ext = {{(XLEN-16){~hd.uns & lsq.mc_rdata[15]}}, lsq.mc_rdata[15:0]};
      default: ld_ext = lsq.mc_rdata;
    endcase
  end

  always_comb begin
    ent_d       = ent_q;
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    cmt_cnt_d   = cmt_cnt_q;
    mc_req_d    = mc_req_q;
    mc_wr_d     = mc_wr_q;
    mc_size_d   = mc_size_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;
    out_valid_d = 1'b0;
    out_rob_d   = out_rob_q;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    st_pop      = 1'b0;
    cmt_hit     = 1'b0;
    off         = '0;
    enq         = lsq.iss_valid && !full && !lsq.flush;

    for (int i = 0; i < N; i++) begin
      {ent_d[i].qi, ent_d[i].vi} = resolve(ent_q[i].qi, ent_q[i].vi);
      {ent_d[i].qj, ent_d[i].vj} = resolve(ent_q[i].qj, ent_q[i].vj);
      off = DEPTH_BITS'(i) - head_q;
      if (lsq.commit_valid && !lsq.flush && ({1'b0, off} < count_q) && ent_q[i].st &&
          !ent_q[i].cmt && ent_q[i].rob == lsq.commit_rob) begin
        ent_d[i].cmt = 1'b1;
        cmt_hit      = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!lsq.flush && head_ready) begin
          mc_req_d   = 1'b1;
          mc_wr_d    = hd.st;
          mc_size_d  = hd.sz;
          mc_addr_d  = hd_addr;
          mc_wdata_d = hd.st ? hd.vj : '0;
          state_d    = WAIT;
        end else if (!lsq.flush && report) begin
          out_valid_d        = 1'b1;
          out_rob_d          = hd.rob;
          out_data_d         = '0;
          ent_d[head_q].rep  = 1'b1;
        end
      end
      WAIT: begin
        if (lsq.mc_done) begin
          pop      = 1'b1;
          mc_req_d = 1'b0;
          state_d  = IDLE;
          if (mc_wr_q) begin
            st_pop = 1'b1;
          end else if (!lsq.flush) begin
            out_valid_d = 1'b1;
            out_rob_d   = hd.rob;
            out_data_d  = ld_ext;
          end
        end else if (lsq.flush && !mc_wr_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (lsq.mc_done) begin
          mc_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enq) begin
      ent_d[tail_q].st  = lsq.iss_op[3];
      ent_d[tail_q].uns = lsq.iss_op[2];
      ent_d[tail_q].sz  = lsq.iss_op[1:0];
      ent_d[tail_q].rob = lsq.iss_rob;
      ent_d[tail_q].imm = lsq.iss_imm;
      ent_d[tail_q].cmt = 1'b0;
      ent_d[tail_q].rep = 1'b0;
      {ent_d[tail_q].qi, ent_d[tail_q].vi} = resolve(lsq.iss_qi, lsq.iss_vi);
      {ent_d[tail_q].qj, ent_d[tail_q].vj} = resolve(lsq.iss_qj, lsq.iss_vj);
      tail_d = tail_q + 1'b1;
    end

    if (cmt_hit) cmt_cnt_d = cmt_cnt_d + 1'b1;
    if (st_pop)  cmt_cnt_d = cmt_cnt_d - 1'b1;
    if (enq)     count_d   = count_d + 1'b1;
    if (pop) begin
      count_d = count_d - 1'b1;
      head_d  = head_q + 1'b1;
    end

    // Committed stores are always the oldest entries, so a flush keeps exactly that prefix.
    if (lsq.flush) begin
      count_d = cmt_cnt_d;
      tail_d  = head_d + cmt_cnt_d[DEPTH_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q       <= '{default: '0};
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cmt_cnt_q   <= '0;
      mc_req_q    <= 1'b0;
      mc_wr_q     <= 1'b0;
      mc_size_q   <= '0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
      out_valid_q <= 1'b0;
      out_rob_q   <= '0;
      out_data_q  <= '0;
    end else if (lsq.rdy) begin
      ent_q       <= ent_d;
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cmt_cnt_q   <= cmt_cnt_d;
      mc_req_q    <= mc_req_d;
      mc_wr_q     <= mc_wr_d;
      mc_size_q   <= mc_size_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
      out_valid_q <= out_valid_d;
      out_rob_q   <= out_rob_d;
      out_data_q  <= out_data_d;
    end
  end

  assign lsq.full      = full;
  assign lsq.mc_req    = mc_req_q;
  assign lsq.mc_wr     = mc_wr_q;
  assign lsq.mc_size   = mc_size_q;
  assign lsq.mc_addr   = mc_addr_q;
  assign lsq.mc_wdata  = mc_wdata_q;
  assign lsq.out_valid = out_valid_q;
  assign lsq.out_rob   = out_rob_q;
  assign lsq.out_data  = out_data_q;
endmodule
